data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, 64, number of 32-bit data words.
REQ-002 SHALL have parameter BASE_ADDR, 1024, byte address mapped to word 0.
REQ-003 SHALL have parameter WAIT_CYCLES, 3, extra wait-state cycles per access (0..15).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port MEM_R_EN  input  1  read request from the EX/MEM pipeline register.
REQ-007 SHALL have port MEM_W_EN  input  1  write request from the EX/MEM pipeline register.
REQ-008 SHALL have port ALU_result  input  32  byte address of the access.
REQ-009 SHALL have port ST_val  input  32  store data.
REQ-010 SHALL have port ready  output  1  high = pipeline may advance; low = freeze upstream.
REQ-011 SHALL have port MEM_result  output  32  registered load data.
REQ-012 SHALL have port misaligned  output  1  one-cycle alignment-fault flag.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 IDLE with MEM_R_EN or MEM_W_EN high SHALL latch address/data, clear wait counter, go to BUSY (or DONE if WAIT_CYCLES=0).
REQ-015 BUSY SHALL increment the wait counter each cycle and go to DONE when it reaches WAIT_CYCLES-1.
REQ-016 DONE SHALL last exactly one cycle and return to IDLE unconditionally.
REQ-017 ready SHALL be combinational: high in IDLE with no request, high in DONE, low otherwise.
REQ-018 Latency: request seen in IDLE at cycle t -> ready low t..t+WAIT_CYCLES, high at t+WAIT_CYCLES+1.
REQ-019 Upstream SHALL hold request inputs stable while ready is low; block uses latched copies only.
REQ-020 Word index SHALL be (address - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits after range check.
REQ-021 Write SHALL commit to the array on the clock edge ending DONE.
REQ-022 Read SHALL load MEM_result on the clock edge ending DONE; MEM_result holds until the next completed read.
REQ-023 Address below BASE_ADDR or >= BASE_ADDR+4*DEPTH: write dropped, read returns 0, still full latency.
REQ-024 MEM_R_EN and MEM_W_EN both high: treated as write only; MEM_result unchanged.
REQ-025 No request in IDLE: state stays IDLE, no array or output change.

Reset
REQ-026 rst high SHALL force state IDLE, wait counter 0, MEM_result 0, misaligned 0, all array words 0.
REQ-027 rst during BUSY/DONE SHALL abort the access: no write committed, MEM_result 0.
REQ-028 After rst release, ready SHALL follow REQ-017 in the first cycle.

Configuration
REQ-029 Macro MEM_ALIGN_CHECK_EN SHALL enable alignment checking.
REQ-030 With MEM_ALIGN_CHECK_EN: latched address[1:0] != 0 -> misaligned high during DONE, write suppressed, read returns 0.
REQ-031 Without MEM_ALIGN_CHECK_EN: misaligned tied 0, address[1:0] ignored.

Verification
REQ-032 WAIT_CYCLES=3: write 0xDEADBEEF to 1024 -> ready low 4 cycles, high 1; later read 1024 -> MEM_result 0xDEADBEEF.
REQ-033 WAIT_CYCLES=0: read 1028 after reset -> ready low 1 cycle, MEM_result 0x00000000.
REQ-034 Write 0x12345678 to 1020 and to 1024+4*64 -> no array change; reads of those return 0.
REQ-035 Assert rst in BUSY of write 0xA5A5A5A5 to 1032 -> read 1032 returns 0.
REQ-036 MEM_R_EN=MEM_W_EN=1, addr 1036, data 0x55 -> read 1036 returns 0x55, MEM_result unchanged during combo.
REQ-037 MEM_ALIGN_CHECK_EN defined: write 0xFF to 1026 -> misaligned pulses 1 cycle in DONE, word 1024 unchanged.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Word-addressed data memory that answers load/store requests from the
// EX/MEM pipeline register after a fixed number of wait states.
// Handshake: 'ready' low freezes the upstream pipeline until the access completes.
// Optional alignment checking is enabled by defining the MEM_ALIGN_CHECK_EN macro.
// Without it, 'misaligned' is tied low and address bits [1:0] are ignored.

module data_mem_responder #(
  parameter int DEPTH       = 64,    // number of 32-bit words
  parameter int BASE_ADDR   = 1024,  // byte address of word 0
  parameter int WAIT_CYCLES = 3      // extra wait states per access, 0..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_result,
  input  logic [31:0] ST_val,
  output logic        ready,
  output logic [31:0] MEM_result,
  output logic        misaligned
);

  localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] BASE      = 32'(BASE_ADDR);
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH);
  // Counter value on which BUSY hands over to DONE; unused when WAIT_CYCLES is 0.
  localparam logic [3:0]  LAST_WAIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // State and latched request.
  logic [1:0]  r_state;
  logic [3:0]  r_wait_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_is_write;
  logic        r_is_read;
  logic [31:0] r_mem_result;
  logic [31:0] r_mem [DEPTH];

  // Decoded request and access qualification.
  logic             w_req;
  logic [1:0]       w_state_next;
  logic [31:0]      w_offset;
  logic             w_in_range;
  logic [IDX_W-1:0] w_index;
  logic             w_align_fault;
  logic             w_access_ok;
  logic             w_commit_write;
  logic             w_commit_read;

  assign w_req = MEM_R_EN | MEM_W_EN;

  // Range check is done on the full byte offset before truncating to a word index,
  // so addresses beyond the array never alias onto a real word.
  assign w_offset   = r_addr - BASE;
  assign w_in_range = (r_addr >= BASE) && (w_offset < SPAN);
  assign w_index    = w_offset[IDX_W+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  assign w_align_fault = (r_addr[1:0] != 2'b00);
  assign misaligned    = (r_state == S_DONE) && w_align_fault;
`else
  assign w_align_fault = 1'b0;
  assign misaligned    = 1'b0;
`endif

  assign w_access_ok    = w_in_range && !w_align_fault;
  assign w_commit_write = (r_state == S_DONE) && r_is_write && w_access_ok;
  assign w_commit_read  = (r_state == S_DONE) && r_is_read;

  // Ready is purely a function of state and the live request: a fresh request
  // seen in IDLE already stalls the pipeline in the same cycle.
  assign ready = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);

  assign MEM_result = r_mem_result;

  // Next-state selection for the IDLE -> BUSY -> DONE access sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_next = (WAIT_CYCLES == 0) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_wait_cnt == LAST_WAIT) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Wait-state counter: cleared when an access is accepted, counts through BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= 4'd0;
    end else if ((r_state == S_IDLE) && w_req) begin
      r_wait_cnt <= 4'd0;
    end else if (r_state == S_BUSY) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  // Capture the request on acceptance; a simultaneous read+write is a write only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_is_write <= 1'b0;
      r_is_read  <= 1'b0;
    end else if ((r_state == S_IDLE) && w_req) begin
      r_addr     <= ALU_result;
      r_wdata    <= ST_val;
      r_is_write <= MEM_W_EN;
      r_is_read  <= MEM_R_EN & ~MEM_W_EN;
    end
  end

  // Storage array; the whole array clears on reset, so it is built from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (w_commit_write) begin
      r_mem[w_index] <= r_wdata;
    end
  end

  // Load data updates only when a read completes; rejected reads return zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_result <= 32'd0;
    end else if (w_commit_read) begin
      r_mem_result <= w_access_ok ? r_mem[w_index] : 32'd0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with 3 wait states, one with none.
// A transaction-level memory model predicts ready/MEM_result/misaligned and a
// negedge compare process checks both instances every cycle.
// Define MEM_ALIGN_CHECK_EN for both bench and RTL to cover alignment checking.

module tb_data_mem_responder;

  localparam int BASE  = 1024;
  localparam int DEPTH = 64;
  localparam int NDUT  = 2;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        r_en   [NDUT];
  logic        w_en   [NDUT];
  logic [31:0] addr   [NDUT];
  logic [31:0] data   [NDUT];
  logic        rdy    [NDUT];
  logic [31:0] res    [NDUT];
  logic        mis    [NDUT];

  // Model state.
  logic        exp_rdy [NDUT];
  logic [31:0] exp_res [NDUT];
  logic        exp_mis [NDUT];
  logic [31:0] mmem    [NDUT][DEPTH];
  int          low_cnt [NDUT];
  int          last_run[NDUT];

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .rst(rst), .MEM_R_EN(r_en[0]), .MEM_W_EN(w_en[0]),
    .ALU_result(addr[0]), .ST_val(data[0]),
    .ready(rdy[0]), .MEM_result(res[0]), .misaligned(mis[0])
  );

  data_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .MEM_R_EN(r_en[1]), .MEM_W_EN(w_en[1]),
    .ALU_result(addr[1]), .ST_val(data[1]),
    .ready(rdy[1]), .MEM_result(res[1]), .misaligned(mis[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_fault(input logic [31:0] a);
    return ALIGN_EN && (a[1:0] != 2'b00);
  endfunction

  function automatic bit m_in_range(input logic [31:0] a);
    return (a >= 32'(BASE)) && (a < 32'(BASE + 4 * DEPTH));
  endfunction

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < DEPTH; i++) mmem[d][i] = 32'h0;
      exp_res[d] = 32'h0;
      exp_mis[d] = 1'b0;
      exp_rdy[d] = 1'b1;
    end
  endtask

  // One complete access: request in IDLE, wait states, DONE, then release.
  task automatic do_access(input int d, input bit rd, input bit wr,
                           input logic [31:0] a, input logic [31:0] v);
    int wc;
    int idx;
    bit ok;
    wc = (d == 0) ? 3 : 0;
    @(posedge clk); #1;
    r_en[d] = rd; w_en[d] = wr; addr[d] = a; data[d] = v;
    exp_rdy[d] = 1'b0;
    repeat (wc) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    exp_rdy[d] = 1'b1;
    exp_mis[d] = m_fault(a);
    @(posedge clk); #1;
    r_en[d] = 1'b0; w_en[d] = 1'b0;
    exp_mis[d] = 1'b0;
    ok = m_in_range(a) && !m_fault(a);
    if (wr) begin
      if (ok) begin
        idx = int'((a - 32'(BASE)) / 32'd4);
        mmem[d][idx] = v;
      end
    end else if (rd) begin
      if (ok) begin
        idx = int'((a - 32'(BASE)) / 32'd4);
        exp_res[d] = mmem[d][idx];
      end else begin
        exp_res[d] = 32'h0;
      end
    end
    $display("txn dut%0d rd=%0b wr=%0b addr=%0d data=%h -> MEM_result=%h",
             d, rd, wr, a, v, res[d]);
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      for (int d = 0; d < NDUT; d++) begin
        chk($sformatf("ready_dut%0d", d), 32'(rdy[d]), 32'(exp_rdy[d]));
        chk($sformatf("MEM_result_dut%0d", d), res[d], exp_res[d]);
        chk($sformatf("misaligned_dut%0d", d), 32'(mis[d]), 32'(exp_mis[d]));
      end
    end
  end

  // Length of the most recent run of stalled cycles per instance.
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (rdy[d] !== 1'b1) begin
        low_cnt[d] <= low_cnt[d] + 1;
      end else begin
        if (low_cnt[d] != 0) last_run[d] <= low_cnt[d];
        low_cnt[d] <= 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      r_en[d] = 1'b0; w_en[d] = 1'b0; addr[d] = 32'h0; data[d] = 32'h0;
      low_cnt[d] = 0; last_run[d] = 0;
    end
    model_reset();
    #2;
    rst = 1'b1;
    check_en = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_result", res[0], 32'h0);
    chk("reset_ready", 32'(rdy[0]), 32'h1);

    // Basic write/read with three wait states.
    do_access(0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    chk("w3_stall_len", 32'(last_run[0]), 32'd4);
    do_access(0, 1'b1, 1'b0, 32'd1024, 32'h0);
    chk("read_1024", res[0], 32'hDEADBEEF);

    // Zero wait states.
    do_access(1, 1'b1, 1'b0, 32'd1028, 32'h0);
    chk("w0_stall_len", 32'(last_run[1]), 32'd1);
    chk("w0_read_1028", res[1], 32'h0);
    do_access(1, 1'b0, 1'b1, 32'd1028, 32'hCAFEF00D);
    do_access(1, 1'b1, 1'b0, 32'd1028, 32'h0);
    chk("w0_read_back", res[1], 32'hCAFEF00D);

    // Out-of-range writes are dropped and reads return zero.
    do_access(0, 1'b0, 1'b1, 32'd1020, 32'h12345678);
    do_access(0, 1'b0, 1'b1, 32'd1280, 32'h12345678);
    do_access(0, 1'b1, 1'b0, 32'd1020, 32'h0);
    chk("read_below_base", res[0], 32'h0);
    do_access(0, 1'b1, 1'b0, 32'd1024, 32'h0);
    chk("word0_intact", res[0], 32'hDEADBEEF);
    do_access(0, 1'b1, 1'b0, 32'd1280, 32'h0);
    chk("read_past_end", res[0], 32'h0);
    do_access(0, 1'b1, 1'b0, 32'd1276, 32'h0);
    chk("last_word_untouched", res[0], 32'h0);
    do_access(0, 1'b0, 1'b1, 32'd1276, 32'h0BADF00D);
    do_access(0, 1'b1, 1'b0, 32'd1276, 32'h0);
    chk("last_word_rw", res[0], 32'h0BADF00D);

    // Reset in the middle of a write aborts it.
    @(posedge clk); #1;
    w_en[0] = 1'b1; addr[0] = 32'd1032; data[0] = 32'hA5A5A5A5;
    exp_rdy[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    w_en[0] = 1'b0;
    model_reset();
    #1;
    chk("abort_result_cleared", res[0], 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    $display("txn dut0 write 1032 aborted by reset");
    do_access(0, 1'b0, 1'b1, 32'd1040, 32'h00000077);
    do_access(0, 1'b1, 1'b0, 32'd1040, 32'h0);
    chk("read_1040", res[0], 32'h00000077);
    do_access(0, 1'b1, 1'b0, 32'd1032, 32'h0);
    chk("aborted_write_absent", res[0], 32'h0);

    // Read and write together behave as a write.
    do_access(0, 1'b1, 1'b0, 32'd1040, 32'h0);
    do_access(0, 1'b1, 1'b1, 32'd1036, 32'h00000055);
    chk("combo_result_held", res[0], 32'h00000077);
    do_access(0, 1'b1, 1'b0, 32'd1036, 32'h0);
    chk("combo_wrote", res[0], 32'h00000055);

    // Unaligned access.
    do_access(0, 1'b0, 1'b1, 32'd1024, 32'h11111111);
    do_access(0, 1'b0, 1'b1, 32'd1026, 32'h000000FF);
    do_access(0, 1'b1, 1'b0, 32'd1024, 32'h0);
    chk("unaligned_effect", res[0], ALIGN_EN ? 32'h11111111 : 32'h000000FF);
    do_access(0, 1'b1, 1'b0, 32'd1026, 32'h0);

    // A spread of words on both instances, written then read back.
    for (int i = 0; i < 4; i++) begin
      do_access(0, 1'b0, 1'b1, 32'(BASE + 4 * (i * 9 + 5)), 32'h10000000 + 32'(i) * 32'h01010101);
      do_access(1, 1'b0, 1'b1, 32'(BASE + 4 * (63 - i * 11)), 32'hF0000000 - 32'(i) * 32'h00300003);
    end
    for (int i = 3; i >= 0; i--) begin
      do_access(0, 1'b1, 1'b0, 32'(BASE + 4 * (i * 9 + 5)), 32'h0);
      do_access(1, 1'b1, 1'b0, 32'(BASE + 4 * (63 - i * 11)), 32'h0);
    end
    chk("spread_dut0_word5", res[0], 32'h10000000);
    chk("spread_dut1_word63", res[1], 32'hF0000000);

    repeat (3) @(posedge clk);
    #1;
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
